// File: rtl/motion_arbiter.sv
// motion_arbiter: drives MOTOR_STAT/DUTY from IR command strobes and proximity,
// with command hold timeout, brake dwell on direction change, obstacle stop and duty ramp.
module motion_arbiter #(
    parameter int CMD_TIMEOUT  = 6000000,
    parameter int DWELL_CYCLES = 5000000,
    parameter int RAMP_DIV     = 500000,
    parameter int DUTY_START   = 20,
    parameter int DUTY_FAST    = 60,
    parameter int DUTY_SLOW    = 40,
    parameter int SLOW_THRESH  = 8,
    parameter int STOP_THRESH  = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       cmd_valid_i,
    input  logic [2:0] cmd_i,
    input  logic [3:0] prox_stat_i,
    output logic [2:0] motor_stat_o,
    output logic [6:0] duty_o,
    output logic [1:0] state_o,
    output logic       obstacle_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, DRIVE = 2'b01, DWELL = 2'b10} state_t;
    localparam logic [2:0] NONE = 3'b000, FWD = 3'b001, LEFT = 3'b010, BRAKE = 3'b011;
    localparam logic [2:0] RIGHT = 3'b100, BACK = 3'b101;
    localparam logic [6:0] START = 7'(DUTY_START > 100 ? 100 : DUTY_START);
    localparam logic [6:0] FAST = 7'(DUTY_FAST > 100 ? 100 : DUTY_FAST);
    localparam logic [6:0] SLOW = 7'(DUTY_SLOW > 100 ? 100 : DUTY_SLOW);
    state_t      state_q;
    logic [2:0]  motor_q, pend_q, pend_d;
    logic [6:0]  duty_q, duty_d, tgt;
    logic [31:0] timer_q, ramp_q, dwell_q;
    logic        obs_q, obs, drive_req, brake_req, fwd_obs, to_dwell, ramp_wrap;
    assign drive_req = cmd_valid_i && (cmd_i == FWD || cmd_i == LEFT || cmd_i == RIGHT || cmd_i == BACK);
    assign brake_req = cmd_valid_i && cmd_i == BRAKE;
    assign obs       = prox_stat_i < 4'(STOP_THRESH);
    assign fwd_obs   = motor_q == FWD && obs;
    assign to_dwell  = brake_req || fwd_obs || (drive_req ? cmd_i != motor_q : timer_q == 32'd1);
    assign ramp_wrap = ramp_q == 32'(RAMP_DIV - 1);
    assign tgt       = ((motor_q == FWD || motor_q == BACK) && prox_stat_i >= 4'(SLOW_THRESH)) ? FAST : SLOW;
    assign duty_d    = duty_q < tgt ? duty_q + 7'd1 : duty_q > tgt ? duty_q - 7'd1 : duty_q;
    // latest request during dwell wins; a brake cancels any pending drive
    assign pend_d    = drive_req ? cmd_i : brake_req ? NONE : pend_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            motor_q <= NONE;
            duty_q  <= '0;
            timer_q <= '0;
            ramp_q  <= '0;
            dwell_q <= '0;
            pend_q  <= NONE;
            obs_q   <= 1'b0;
        end else begin
            obs_q <= obs;
            case (state_q)
                IDLE: begin
                    if (drive_req && !(cmd_i == FWD && obs)) begin
                        state_q <= DRIVE;
                        motor_q <= cmd_i;
                        duty_q  <= START;
                        timer_q <= 32'(CMD_TIMEOUT);
                        ramp_q  <= '0;
                    end else if (brake_req) begin
                        state_q <= DWELL;
                        motor_q <= BRAKE;
                        duty_q  <= '0;
                        dwell_q <= '0;
                        pend_q  <= NONE;
                    end
                end
                DRIVE: begin
                    if (to_dwell) begin
                        state_q <= DWELL;
                        motor_q <= BRAKE;
                        duty_q  <= '0;
                        dwell_q <= '0;
                        pend_q  <= (drive_req && !fwd_obs) ? cmd_i : NONE;
                    end else begin
                        timer_q <= drive_req ? 32'(CMD_TIMEOUT) : timer_q - 32'd1;
                        ramp_q  <= ramp_wrap ? '0 : ramp_q + 32'd1;
                        if (ramp_wrap) duty_q <= duty_d;
                    end
                end
                DWELL: begin
                    pend_q <= pend_d;
                    if (dwell_q == 32'(DWELL_CYCLES - 1)) begin
                        if (pend_d == NONE || (pend_d == FWD && obs)) begin
                            state_q <= IDLE;
                            motor_q <= NONE;
                        end else begin
                            state_q <= DRIVE;
                            motor_q <= pend_d;
                            duty_q  <= START;
                            timer_q <= 32'(CMD_TIMEOUT);
                            ramp_q  <= '0;
                        end
                    end else begin
                        dwell_q <= dwell_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign motor_stat_o = motor_q;
    assign duty_o       = duty_q;
    assign state_o      = state_q;
    assign obstacle_o   = obs_q;
endmodule
